// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and sizing helpers for the FWFT FIFO
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic has_data;
        logic almost_full;
        logic full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, synchronous write-first read
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ENTRIES    = 15
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    // Write-first so a word written to the read address is visible on the next cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_fwft_ovf.sv
// rtl/sync_fifo_fwft_ovf.sv - single-clock FWFT FIFO with sticky over/underflow flags
// Define SYNC_FIFO_FWFT_DROP_CNT_EN to build the saturating drop counter.
module sync_fifo_fwft_ovf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int RESERVE        = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      has_data,
    output logic                      empty,
    output logic [ADDR_WIDTH:0]       count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_flags,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int DEPTH    = depth_of(ADDR_WIDTH);
    localparam int BODY     = DEPTH - 1;
    localparam int CW       = count_width(ADDR_WIDTH);
    localparam int AF_LEVEL = (RESERVE >= DEPTH) ? 0 : DEPTH - RESERVE;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(BODY - 1);

    fifo_flags_t           flags;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] body_cnt, wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [DATA_WIDTH-1:0] ram_q;
    logic wr_acc, rd_acc, head_free, load_body, load_wr, body_wr, ovf_evt, udf_evt;

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // The output register refills from the RAM head, or directly from wr_data when the RAM is empty.
    always_comb begin
        wr_acc     = wr_en & ~flags.full;
        rd_acc     = rd_en & flags.has_data;
        ovf_evt    = wr_en & flags.full;
        udf_evt    = rd_en & flags.empty;
        head_free  = ~flags.has_data | rd_acc;
        load_body  = head_free & (body_cnt != '0);
        load_wr    = head_free & (body_cnt == '0) & wr_acc;
        body_wr    = wr_acc & ~load_wr;
        rd_ptr_nxt = load_body ? next_ptr(rd_ptr) : rd_ptr;
        cnt_nxt    = cnt;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // RAM is addressed with the post-edge head pointer so its output is always the next word.
    fifo_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .ENTRIES   (BODY)
    ) u_ram (
        .clk  (clk),
        .we   (body_wr),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr_nxt),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            body_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            flags    <= '{empty: 1'b1, has_data: 1'b0, almost_full: (RESERVE >= DEPTH),
                          full: 1'b0, overflow: 1'b0, underflow: 1'b0};
        end else begin
            cnt    <= cnt_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (body_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            case ({body_wr, load_body})
                2'b10:   body_cnt <= body_cnt + ADDR_WIDTH'(1);
                2'b01:   body_cnt <= body_cnt - ADDR_WIDTH'(1);
                default: body_cnt <= body_cnt;
            endcase
            if (load_body) begin
                rd_data <= ram_q;
            end else if (load_wr) begin
                rd_data <= wr_data;
            end
            flags.empty       <= (cnt_nxt == '0);
            flags.has_data    <= (cnt_nxt != '0);
            flags.full        <= (cnt_nxt == CW'(DEPTH));
            flags.almost_full <= (cnt_nxt >= CW'(AF_LEVEL));
            if (ovf_evt) begin
                flags.overflow <= 1'b1;
            end else if (clr_flags) begin
                flags.overflow <= 1'b0;
            end
            if (udf_evt) begin
                flags.underflow <= 1'b1;
            end else if (clr_flags) begin
                flags.underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drops <= '0;
        end else if (ovf_evt) begin
            if (clr_flags) begin
                drops <= DROP_CNT_WIDTH'(1);
            end else if (~&drops) begin
                drops <= drops + DROP_CNT_WIDTH'(1);
            end
        end else if (clr_flags) begin
            drops <= '0;
        end
    end

    assign drop_cnt = drops;
`else
    assign drop_cnt = '0;
`endif

    assign count       = cnt;
    assign full        = flags.full;
    assign almost_full = flags.almost_full;
    assign has_data    = flags.has_data;
    assign empty       = flags.empty;
    assign overflow    = flags.overflow;
    assign underflow   = flags.underflow;

endmodule

// File: tb/tb_sync_fifo_fwft_ovf.sv
// tb/tb_sync_fifo_fwft_ovf.sv - scoreboard bench for sync_fifo_fwft_ovf
module tb_sync_fifo_fwft_ovf;

    localparam int DEPTH = 16;
    localparam int AF_LEVEL = 8;
`ifdef SYNC_FIFO_FWFT_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en, clr_flags;
    logic [7:0]  wr_data;
    logic        full, almost_full, has_data, empty, overflow, underflow;
    logic [7:0]  rd_data;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    sync_fifo_fwft_ovf #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(8), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .has_data(has_data), .empty(empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_flags(clr_flags), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf, m_udf;
    int         m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int n = mq.size();
        chk({tag, " count"}, 32'(count), n);
        chk({tag, " empty"}, 32'(empty), 32'(n == 0));
        chk({tag, " has_data"}, 32'(has_data), 32'(n != 0));
        chk({tag, " full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= AF_LEVEL));
        chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(m_udf));
        chk({tag, " drop_cnt"}, 32'(drop_cnt), DROP_EN ? m_drops : 0);
    endtask

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cycle(input string tag, input logic w, input logic [7:0] d,
                         input logic r, input logic c);
        bit was_full, was_empty;
        wr_en = w; wr_data = d; rd_en = r; clr_flags = c;
        if (r && mq.size() > 0) exp_q.push_back(mq[0]);
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (r && !was_empty) void'(mq.pop_front());
        if (w && !was_full) mq.push_back(d);
        if (w && was_full) begin
            m_ovf   = 1'b1;
            m_drops = c ? 1 : ((m_drops == 65535) ? m_drops : m_drops + 1);
        end else if (c) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        if (r && was_empty) m_udf = 1'b1;
        else if (c) m_udf = 1'b0;
        #1;
        check_status(tag);
    endtask

    // Monitor: every pop the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (rd_en && has_data) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%0h expected=none", rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; wr_data = '0;
        m_ovf = 1'b0; m_udf = 1'b0; m_drops = 0;
        #3;
        check_status("reset");
        chk("reset rd_data", 32'(rd_data), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) cycle("fill20", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle("drain16", 1'b0, 8'h00, 1'b1, 1'b0);

        cycle("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single_wr rd_data", 32'(rd_data), 32'h A5);
        cycle("single_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        cycle("stream_prime", 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 50; i++) cycle("stream", 1'b1, 8'(i), 1'b1, 1'b0);
        cycle("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle("full_wr_rd", 1'b1, 8'hEE, 1'b1, 1'b0);
        while (mq.size() > 0) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        cycle("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("clear", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle("fill_c", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle("ovf_pre", 1'b1, 8'hFF, 1'b0, 1'b0);
        cycle("clr_vs_ovf", 1'b1, 8'hFE, 1'b0, 1'b1);
        while (mq.size() > 0) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("clear2", 1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 9; i++) cycle("pre_rst", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_drops = 0;
        check_status("async_rst");
        chk("async_rst rd_data", 32'(rd_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst rd_data", 32'(rd_data), 32'h3C);
        cycle("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int ph = 0; ph < 4; ph++) begin
            int wp = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 50 : 90;
            int rp = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 90;
            for (int i = 0; i < 300; i++) begin
                cycle("random", $urandom_range(0, 99) < wp, 8'($urandom),
                      $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 2);
            end
        end
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
